egg_timer_control_unit: RTL and testbench
=========================================

# egg_timer_control_unit

Control unit for the egg timer. It sequences the four BCD time digits through setting, countdown, pause and alarm. Inputs are the two push-buttons, the 8 switches and the 1 Hz enable pulse from the clock divider. Digit outputs drive the four 7-segment decoders directly, and `ledr` shows the current mode or flashes the alarm.

## Interface
- `MAX_TENS`, default 5: upper legal value for both tens digits (time range 00:00–59:59).
- `MAX_ONES`, default 9: upper legal value for both ones digits.
- `clk` in 1: system clock (50 MHz board clock).
- `reset` in 1: asynchronous, active-high; the only reset.
- `key_set_n` in 1: raw push-button (KEY[0]), active-low, asynchronous to `clk`.
- `key_run_n` in 1: raw push-button (KEY[1]), active-low, asynchronous to `clk`.
- `sw` in 8: `sw[7:4]` tens digit, `sw[3:0]` ones digit for the field being set.
- `tick` in 1: one-`clk` pulse per second from the clock divider.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: registered BCD digits.
- `ledr` out 10: registered mode/alarm LEDs.

## Operation
- **Key handling.** Each key passes through a 2-flop synchronizer, then a falling-edge detector. Each physical press produces exactly one `press` pulse of one cycle. Holding a key produces no repeats.
- **States.** The FSM has five states: `SET_SEC`, `SET_MIN`, `RUN`, `PAUSE`, `DONE`.
- **`ledr` per state:**
  - `SET_SEC` = 0x001
  - `SET_MIN` = 0x002
  - `RUN` = 0x004
  - `PAUSE` = 0x008
  - `DONE` = 0x3FF on entry, then inverted on every `tick`
- **Switch clamping.** In `SET_SEC` and `SET_MIN`, the selected field loads from `sw` every cycle (live follow):
  - tens = min(`sw[7:4]`, `MAX_TENS`)
  - ones = min(`sw[3:0]`, `MAX_ONES`)
  - The other field holds its value.
- **`SET_SEC` transitions:**
  - set press → `SET_MIN`.
  - run press → `RUN` if time ≠ 00:00, else stay.
- **`SET_MIN` transitions:**
  - set press → `SET_SEC`.
  - run press → as in `SET_SEC`.
- **`RUN`:**
  - On `tick`, decrement the time as BCD:
    - `sec_ones` > 0 → `sec_ones` − 1.
    - Otherwise `sec_ones` = 9 and borrow: `sec_tens` − 1, or `sec_tens` = 5 with a further borrow into the minutes.
    - Minutes decrement the same way, `min_tens` range 0–5.
  - If the decrement result is 00:00, enter `DONE` on the same edge.
  - run press → `PAUSE`.
  - set press is ignored.
- **`PAUSE`:** time holds.
  - run press → `RUN`.
  - set press → `SET_SEC`.
- **`DONE`:** digits hold 00:00. Any press → `SET_SEC`, with `ledr` = 0x001.
- **Ignored `tick`.** `tick` is ignored in every state except `RUN` and `DONE`.
- **Simultaneous events:**
  - set press and run press together: set wins, except in `RUN`, where set is ignored and run acts.
  - run press and `tick` together in `RUN`: go to `PAUSE` with no decrement.
  - Any press and `tick` together in `DONE`: go to `SET_SEC`, no flash.

## Timing
- **Reset values (asynchronous, immediate):**
  - FSM state = `SET_SEC`.
  - All digits = 0.
  - `ledr` = 0x001.
  - Synchronizer and edge-detect flops = 1 (keys released).
- **Reset mid-operation:** a reset during any state returns to these values asynchronously, with no partial decrement.
- **Key-to-state latency.** If a key is first sampled low at rising edge N, the state and `ledr` change at edge N+2. There is no further output delay.
- **Tick-to-digit latency.** A `tick` high during the cycle before edge M updates the digits at edge M. On the final second, the digits and `DONE` update at the same edge M.
- **Switch-to-digit latency.** Switch changes in the set states appear on the digits one edge later. The switches are quasi-static, so no synchronizer is required for them.
- **Register rule.** All outputs come straight from flops, with no combinational path from inputs to outputs.

## Structure
- **Package `egg_timer_pkg`:**
  - state enum (`SET_SEC`, `SET_MIN`, `RUN`, `PAUSE`, `DONE`)
  - `ledr` mode-pattern constants
  - BCD digit-limit constants
  - a BCD-time decrement function over the four 4-bit digits, also used by the testbench model
- **Sub-module `key_press_detect`:**
  - ports: `clk`, `reset`, `key_n` in, `press` out
  - content: 2-flop synchronizer plus falling-edge detect
  - instantiated once per key.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-cycle → digits 0/0/0/0 and `ledr` = 0x001 before the next edge. Repeat during `RUN` at 12:34 → same result.
- **Switch clamping.** In `SET_SEC`: `sw` = 0x45 → `sec_tens`/`sec_ones` = 4/5. Then `sw` = 0x7C → 5/9. A set press followed by `sw` = 0x12 → min 1/2, and seconds stay 5/9.
- **Minute borrow.** Load 01:00, press run, pulse `tick` once → 00:59 and `ledr` = 0x004. Load 10:00 and tick once → 09:59.
- **Alarm.** Load 00:02, run, two ticks → 00:00, `DONE`, `ledr` = 0x3FF. Next tick → 0x000, next → 0x3FF. Run press → `SET_SEC`, `ledr` = 0x001.
- **Pause priority and empty start.**
  - In `RUN` at 00:30, `tick` coincident with a run press → `PAUSE` and 00:30 unchanged.
  - A run press from `PAUSE` → `RUN`.
  - A run press at 00:00 in `SET_SEC` → state stays `SET_SEC`.
- **Key edge detection.** Hold `key_run_n` low for 1000 cycles → exactly one transition, at edge N+2. A glitch-free release and a second press → a second transition.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types, LED patterns and BCD helpers for the egg timer control unit.
package egg_timer_pkg;

   typedef enum logic [2:0] {
      SET_SEC,
      SET_MIN,
      RUN,
      PAUSE,
      DONE
   } state_e;

   localparam logic [9:0] LED_SET_SEC = 10'h001;
   localparam logic [9:0] LED_SET_MIN = 10'h002;
   localparam logic [9:0] LED_RUN     = 10'h004;
   localparam logic [9:0] LED_PAUSE   = 10'h008;
   localparam logic [9:0] LED_ALARM   = 10'h3FF;

   localparam logic [3:0] BCD_TENS_MAX = 4'd5;
   localparam logic [3:0] BCD_ONES_MAX = 4'd9;

   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } bcd_time_t;

   function automatic logic [3:0] clamp(input logic [3:0] v,
                                        input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Ripple borrow from seconds ones up to minutes tens.
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_ones != 4'd0) begin
         r.sec_ones = t.sec_ones - 4'd1;
      end else begin
         r.sec_ones = BCD_ONES_MAX;
         if (t.sec_tens != 4'd0) begin
            r.sec_tens = t.sec_tens - 4'd1;
         end else begin
            r.sec_tens = BCD_TENS_MAX;
            if (t.min_ones != 4'd0) begin
               r.min_ones = t.min_ones - 4'd1;
            end else begin
               r.min_ones = BCD_ONES_MAX;
               if (t.min_tens != 4'd0) r.min_tens = t.min_tens - 4'd1;
               else                    r.min_tens = BCD_TENS_MAX;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/egg_timer_control_unit_key_press_detect.sv
// Push-button synchronizer with falling-edge detect: one pulse per press.
module key_press_detect (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], key_n};
      prev_d = sync_q[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign press = prev_q & ~sync_q[1];

endmodule

// File: rtl/egg_timer_control_unit.sv
// Egg timer sequencer: set, countdown, pause and alarm over four BCD digits.
import egg_timer_pkg::*;

module egg_timer_control_unit #(
   parameter int unsigned MAX_TENS = 5,
   parameter int unsigned MAX_ONES = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_set_n,
   input  logic       key_run_n,
   input  logic [7:0] sw,
   input  logic       tick,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [9:0] ledr
);

   localparam logic [3:0] TMAX = MAX_TENS[3:0];
   localparam logic [3:0] OMAX = MAX_ONES[3:0];

   logic      set_press, run_press;
   state_e    state_q, state_d;
   bcd_time_t t_q, t_d, ld, dec;
   logic [9:0] ledr_q, ledr_d;

   key_press_detect u_key_set (
      .clk   (clk),
      .reset (reset),
      .key_n (key_set_n),
      .press (set_press)
   );

   key_press_detect u_key_run (
      .clk   (clk),
      .reset (reset),
      .key_n (key_run_n),
      .press (run_press)
   );

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      ld      = t_q;
      dec     = bcd_dec(t_q);
      unique case (state_q)
         SET_SEC, SET_MIN: begin
            if (state_q == SET_SEC) begin
               ld.sec_tens = clamp(sw[7:4], TMAX);
               ld.sec_ones = clamp(sw[3:0], OMAX);
            end else begin
               ld.min_tens = clamp(sw[7:4], TMAX);
               ld.min_ones = clamp(sw[3:0], OMAX);
            end
            t_d = ld;
            if (set_press)
               state_d = (state_q == SET_SEC) ? SET_MIN : SET_SEC;
            else if (run_press && ld != '0)
               state_d = RUN;
         end
         RUN: begin
            // A run press pre-empts a coincident tick.
            if (run_press) begin
               state_d = PAUSE;
            end else if (tick) begin
               t_d = dec;
               if (dec == '0) state_d = DONE;
            end
         end
         PAUSE: begin
            if (set_press)      state_d = SET_SEC;
            else if (run_press) state_d = RUN;
         end
         DONE: begin
            t_d = '0;
            if (set_press || run_press) state_d = SET_SEC;
         end
         default: state_d = SET_SEC;
      endcase
   end

   always_comb begin
      ledr_d = ledr_q;
      unique case (state_d)
         SET_SEC: ledr_d = LED_SET_SEC;
         SET_MIN: ledr_d = LED_SET_MIN;
         RUN:     ledr_d = LED_RUN;
         PAUSE:   ledr_d = LED_PAUSE;
         DONE: begin
            if (state_q != DONE) ledr_d = LED_ALARM;
            else if (tick)       ledr_d = ~ledr_q;
         end
         default: ledr_d = LED_SET_SEC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SET_SEC;
         t_q     <= '0;
         ledr_q  <= LED_SET_SEC;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         ledr_q  <= ledr_d;
      end
   end

   assign min_tens = t_q.min_tens;
   assign min_ones = t_q.min_ones;
   assign sec_tens = t_q.sec_tens;
   assign sec_ones = t_q.sec_ones;
   assign ledr     = ledr_q;

endmodule

// File: tb/tb_egg_timer_control_unit.sv
// Bench for egg_timer_control_unit: directed plan plus random keys/ticks
// against a seconds-count reference model.
module tb_egg_timer_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_set_n = 1'b1;
   logic       key_run_n = 1'b1;
   logic [7:0] sw = 8'h00;
   logic       tick = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic [9:0] ledr;

   always #5 clk = ~clk;

   egg_timer_control_unit #(.MAX_TENS(5), .MAX_ONES(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_set_n (key_set_n),
      .key_run_n (key_run_n),
      .sw        (sw),
      .tick      (tick),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .ledr      (ledr)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: time as a plain seconds count, mode as small ints.
   localparam int M_SS = 0, M_SM = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
   int         m_mode = M_SS;
   int         m_secs = 0;
   logic [9:0] m_led = 10'h001;
   logic [2:0] hs = 3'b111, hr = 3'b111;

   initial forever begin
      int pm, ct, co;
      bit sp, rp;
      @(posedge clk or posedge reset);
      if (reset) begin
         m_mode = M_SS; m_secs = 0; m_led = 10'h001;
         hs = 3'b111; hr = 3'b111;
      end else begin
         // a press acts two edges after the key is first seen low
         sp = !hs[1] && hs[2];
         rp = !hr[1] && hr[2];
         hs = {hs[1:0], key_set_n};
         hr = {hr[1:0], key_run_n};
         pm = m_mode;
         ct = (sw[7:4] > 4'd5) ? 5 : int'(sw[7:4]);
         co = (sw[3:0] > 4'd9) ? 9 : int'(sw[3:0]);
         case (m_mode)
            M_SS, M_SM: begin
               if (m_mode == M_SS) m_secs = (m_secs / 60) * 60 + ct * 10 + co;
               else                m_secs = (ct * 10 + co) * 60 + m_secs % 60;
               if (sp)                      m_mode = (m_mode == M_SS) ? M_SM : M_SS;
               else if (rp && m_secs != 0)  m_mode = M_RUN;
            end
            M_RUN: begin
               if (rp) m_mode = M_PAUSE;
               else if (tick) begin
                  m_secs = m_secs - 1;
                  if (m_secs == 0) m_mode = M_DONE;
               end
            end
            M_PAUSE: begin
               if (sp)      m_mode = M_SS;
               else if (rp) m_mode = M_RUN;
            end
            default: if (sp || rp) m_mode = M_SS;
         endcase
         case (m_mode)
            M_SS:    m_led = 10'h001;
            M_SM:    m_led = 10'h002;
            M_RUN:   m_led = 10'h004;
            M_PAUSE: m_led = 10'h008;
            default: m_led = (pm != M_DONE) ? 10'h3FF : (tick ? ~m_led : m_led);
         endcase
      end
   end

   always @(negedge clk) begin
      logic [25:0] e;
      if (chk_en) begin
         e = {4'(m_secs / 600), 4'((m_secs / 60) % 10),
              4'((m_secs % 60) / 10), 4'(m_secs % 10), m_led};
         chk("model", {min_tens, min_ones, sec_tens, sec_ones, ledr}, e);
      end
   end

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input bit run);
      if (run) key_run_n = 1'b0; else key_set_n = 1'b0;
      cyc(3);
      key_run_n = 1'b1;
      key_set_n = 1'b1;
      cyc(4);
   endtask

   task automatic pulse_tick;
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
   endtask

   // From SET_SEC, leaves the unit in SET_MIN showing mm:ss.
   task automatic set_time(input int mm, input int ss);
      sw = bcd(ss);
      cyc(2);
      press(0);
      sw = bcd(mm);
      cyc(2);
   endtask

   function automatic logic [15:0] digits();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic async_reset(input string tag);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk({tag, "_digits"}, 32'(digits()), 32'h0000);
      chk({tag, "_ledr"}, 32'(ledr), 32'h001);
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(2);
   endtask

   initial begin
      cyc(3);
      reset = 1'b0;
      chk_en = 1;
      cyc(2);
      async_reset("rst_idle");

      sw = 8'h45; cyc(2);
      chk("clamp_45", 32'(digits()), 32'h0045);
      sw = 8'h7C; cyc(2);
      chk("clamp_7c", 32'(digits()), 32'h0059);
      press(0);
      sw = 8'h12; cyc(2);
      chk("set_min", 32'(digits()), 32'h1259);
      chk("led_setmin", 32'(ledr), 32'h002);

      press(0);
      set_time(1, 0);
      press(1);
      chk("led_run", 32'(ledr), 32'h004);
      pulse_tick;
      chk("borrow_0100", 32'(digits()), 32'h0059);
      press(1); press(0);
      set_time(10, 0);
      press(1);
      pulse_tick;
      chk("borrow_1000", 32'(digits()), 32'h0959);

      press(1); press(0);
      set_time(0, 2);
      press(1);
      pulse_tick; pulse_tick;
      chk("alarm_time", 32'(digits()), 32'h0000);
      chk("alarm_on", 32'(ledr), 32'h3FF);
      pulse_tick;
      chk("alarm_off", 32'(ledr), 32'h000);
      pulse_tick;
      chk("alarm_on2", 32'(ledr), 32'h3FF);
      press(1);
      chk("alarm_exit", 32'(ledr), 32'h001);

      set_time(0, 30);
      press(1);
      key_run_n = 1'b0;
      cyc(2);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      key_run_n = 1'b1;
      cyc(4);
      chk("pause_prio_t", 32'(digits()), 32'h0030);
      chk("pause_prio_l", 32'(ledr), 32'h008);
      press(1);
      chk("resume", 32'(ledr), 32'h004);
      press(1); press(0);
      sw = 8'h00; cyc(2);
      press(1);
      chk("empty_start", 32'(ledr), 32'h001);

      sw = 8'h30; cyc(2);
      key_run_n = 1'b0;
      cyc(1);
      chk("edge_n", 32'(ledr), 32'h001);
      cyc(1);
      chk("edge_n1", 32'(ledr), 32'h001);
      cyc(1);
      chk("edge_n2", 32'(ledr), 32'h004);
      cyc(1000);
      chk("hold_led", 32'(ledr), 32'h004);
      key_run_n = 1'b1;
      cyc(4);
      press(1);
      chk("second_press", 32'(ledr), 32'h008);

      press(0);
      set_time(12, 34);
      press(1);
      chk("run_1234", 32'(digits()), 32'h1234);
      async_reset("rst_run");

      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(9) == 0) key_set_n = ~key_set_n;
         if ($urandom_range(7) == 0) key_run_n = ~key_run_n;
         tick = ($urandom_range(3) == 0);
         if ($urandom_range(19) == 0)
            sw = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom);
         cyc(1);
      end
      tick = 1'b0;
      key_set_n = 1'b1;
      key_run_n = 1'b1;
      cyc(4);

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
